// File: rtl/lsu_subword.sv
// Purpose: RV32I load/store unit that turns byte/half/word accesses into whole-word
//          accesses on a single-port data memory; sub-word stores use read-modify-write.
// Latency: loads and errors respond 1 cycle after accept; stores write and respond in
//          the following WRITE cycle.
// Backpressure: req_ready drops for the WRITE cycle of a store; loads sustain 1/cycle.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   req_valid/ready   request handshake; req_we, funct3, addr, wdata describe the access
//   rsp_valid/err     one-cycle response pulse; err flags misaligned or illegal funct3
//   rdata             extended load result (0 for stores and errors, held otherwise)
//   mem_A/WD/WE/RD    word-indexed data memory port (RD is combinational)
module lsu_subword #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [MEM_AW-1:0] r_idx;
  logic [31:0]       r_merged;
  logic [31:0]       r_rdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;

  logic [MEM_AW-1:0] w_idx;
  logic [MEM_AW-1:0] w_mem_idx;
  logic [1:0]        w_off;
  logic [1:0]        w_size;
  logic              w_unsigned;
  logic              w_f3_legal;
  logic              w_misaligned;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;
  logic              w_take_load;
  logic              w_take_store;
  logic              w_take_err;
  logic              w_unused_addr;

  // Address bits above the memory range are dropped so accesses wrap.
  assign w_idx         = addr[MEM_AW+1:2];
  assign w_unused_addr = ^addr[31:MEM_AW+2];
  assign w_off         = addr[1:0];
  assign w_size        = funct3[1:0];
  assign w_unsigned    = funct3[2];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // Loads allow 000/001/010/100/101; stores only 000/001/010. Size code 11 is
  // never legal, and the unsigned bit is meaningless for words and stores.
  always_comb begin
    if (req_we) begin
      w_f3_legal = !funct3[2] && (w_size != 2'b11);
    end else begin
      w_f3_legal = (w_size != 2'b11) && !(funct3[2] && funct3[1]);
    end
  end

  assign w_misaligned = ((w_size == 2'b01) && w_off[0]) ||
                        ((w_size == 2'b10) && (w_off != 2'b00));
  assign w_err        = !w_f3_legal || w_misaligned;

  // ---------------------------------------------------------------------------
  // Load lane select and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    w_byte = mem_RD[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? mem_RD[31:16] : mem_RD[15:0];
    w_load = mem_RD;
    case (w_size)
      2'b00:   w_load = {{24{!w_unsigned && w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{!w_unsigned && w_half[15]}}, w_half};
      default: w_load = mem_RD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: insert the new lane into the word currently in memory
  // ---------------------------------------------------------------------------
  always_comb begin
    w_merged = mem_RD;
    case (w_size)
      2'b00: w_merged[{w_off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (w_off[1]) begin
          w_merged[31:16] = wdata[15:0];
        end else begin
          w_merged[15:0] = wdata[15:0];
        end
      end
      default: w_merged = wdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and accept classification
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_take_load  = 1'b0;
    w_take_store = 1'b0;
    w_take_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err) begin
            w_take_err = 1'b1;
          end else if (req_we) begin
            w_take_store = 1'b1;
            w_state_nxt  = S_WRITE;
          end else begin
            w_take_load = 1'b1;
          end
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 32'h0;
      r_merged    <= 32'h0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // A store's response is reported during its WRITE cycle.
      r_rsp_valid <= w_take_load || w_take_store || w_take_err;
      r_rsp_err   <= w_take_err;
      if (w_take_load) begin
        r_rdata <= w_load;
      end else if (w_take_store || w_take_err) begin
        r_rdata <= 32'h0;
      end
      if (w_take_store) begin
        r_merged <= w_merged;
        r_idx    <= w_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = (r_state == S_IDLE);

  // In WRITE the address comes from the register: the requester may already
  // be presenting the next access on addr.
  assign w_mem_idx = (r_state == S_IDLE) ? w_idx : r_idx;
  assign mem_A     = {{(32-MEM_AW){1'b0}}, w_mem_idx};
  assign mem_WD    = r_merged;

  // Reset asserted during WRITE must abort the write and its response within
  // the same cycle, so both are qualified by rst combinationally.
  assign mem_WE    = (r_state == S_WRITE) && rst;
  assign rsp_valid = r_rsp_valid && rst;
  assign rsp_err   = r_rsp_err && rst;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_lsu_subword.sv
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rdata;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_subword #(.MEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rdata(rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  // Data memory attached to the DUT.
  logic [31:0] mem [1024];
  bit          mem_inited = 1'b0;
  assign mem_RD = mem[mem_A[9:0]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (mem_WE) begin
      mem[mem_A[9:0]] <= mem_WD;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural memory plus the expected response of the
  // current cycle. A store occupies two cycles; its data commits at the end of
  // the second unless reset intervenes.
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [1024];
  bit          m_init = 1'b0;
  bit          started = 1'b0;
  bit          m_busy = 1'b0;
  logic        e_vld = 1'b0, e_err = 1'b0, e_we = 1'b0;
  logic [31:0] e_rd = 32'h0, e_wd = 32'h0;
  logic [31:0] e_wa = 32'h0;

  always @(posedge clk) begin
    logic [31:0] word, v, mask;
    int          nb, off;
    bit          legal;
    if (!m_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      m_init = 1'b1;
    end
    if (!rst) begin
      started = 1'b1;
      m_busy  = 1'b0;
      e_vld = 1'b0; e_err = 1'b0; e_we = 1'b0; e_rd = 32'h0;
    end else if (m_busy) begin
      ref_mem[e_wa] = e_wd;
      m_busy = 1'b0;
      e_vld = 1'b0; e_err = 1'b0; e_we = 1'b0;
    end else if (req_valid) begin
      nb    = 1 << funct3[1:0];
      off   = int'(addr % 4);
      word  = ref_mem[(addr >> 2) % 1024];
      legal = req_we ? (funct3 inside {3'd0, 3'd1, 3'd2})
                     : (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mask  = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      e_vld = 1'b1;
      e_we  = 1'b0;
      if (!legal || (off % nb) != 0) begin
        e_err = 1'b1;
        e_rd  = 32'h0;
      end else if (!req_we) begin
        e_err = 1'b0;
        v = (word >> (8 * off)) & mask;
        if (nb < 4 && !funct3[2] && v[8*nb-1]) v = v | ~mask;
        e_rd = v;
      end else begin
        e_err  = 1'b0;
        e_rd   = 32'h0;
        e_we   = 1'b1;
        e_wa   = (addr >> 2) % 1024;
        e_wd   = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        m_busy = 1'b1;
      end
    end else begin
      e_vld = 1'b0; e_err = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_vld && rst});
      chk("rsp_err",   {31'b0, rsp_err},   {31'b0, e_vld && e_err && rst});
      chk("rdata",     rdata, e_rd);
      chk("mem_WE",    {31'b0, mem_WE}, {31'b0, e_we && rst});
      if (m_busy) begin
        chk("mem_A_wr", mem_A, e_wa);
        if (e_we && rst) chk("mem_WD", mem_WD, e_wd);
      end else begin
        chk("mem_A_rd", mem_A, (addr >> 2) % 1024);
      end
    end
  end

  // Issue one request, wait (bounded) for acceptance, sample the response cycle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output logic wr);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("req_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    err = rsp_err; rd = rdata; wr = mem_WE;
  endtask

  logic        r_err, r_wr;
  logic [31:0] r_rd;
  logic [31:0] b2b_exp [4] = '{32'hFFFFFFEF, 32'hFFFFFFAA, 32'h00000001, 32'hFFFFFF80};

  initial begin
    int diffs;
    // Reset with a store presented: nothing may be accepted or written.
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    addr = 32'h10; wdata = 32'h55;
    repeat (2) begin
      @(negedge clk);
      chk("rst_we", {31'b0, mem_WE}, 32'd0);
      chk("rst_vld", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem4", mem[4], 32'hA5A50004);

    // SW then LW
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r_err, r_rd, r_wr);
    chk("sw_err", {31'b0, r_err}, 32'd0);
    chk("sw_we", {31'b0, r_wr}, 32'd1);
    chk("sw_rd", r_rd, 32'd0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r_err, r_rd, r_wr);
    chk("lw_rd", r_rd, 32'hDEADBEEF);
    chk("lw_we", {31'b0, r_wr}, 32'd0);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);

    // SB then LB / LBU
    do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, r_err, r_rd, r_wr);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, r_err, r_rd, r_wr);
    chk("sb_mem4", mem[4], 32'hDEADAAEF);
    chk("lb_rd", r_rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 32'h11, 32'h0, r_err, r_rd, r_wr);
    chk("lbu_rd", r_rd, 32'h000000AA);

    // SH then LH / LHU
    do_req(1'b1, 3'b001, 32'h12, 32'h00008001, r_err, r_rd, r_wr);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, r_err, r_rd, r_wr);
    chk("lh_rd", r_rd, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, r_err, r_rd, r_wr);
    chk("lhu_rd", r_rd, 32'h00008001);
    chk("sh_mem4", mem[4], 32'h8001AAEF);

    // Misaligned and illegal accesses
    do_req(1'b0, 3'b010, 32'h13, 32'h0, r_err, r_rd, r_wr);
    chk("lw_mis_err", {31'b0, r_err}, 32'd1);
    chk("lw_mis_rd", r_rd, 32'd0);
    do_req(1'b1, 3'b001, 32'h11, 32'hFFFF, r_err, r_rd, r_wr);
    chk("sh_mis_err", {31'b0, r_err}, 32'd1);
    chk("sh_mis_we", {31'b0, r_wr}, 32'd0);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, r_err, r_rd, r_wr);
    chk("f3_011_err", {31'b0, r_err}, 32'd1);
    do_req(1'b1, 3'b100, 32'h10, 32'hFF, r_err, r_rd, r_wr);
    chk("st_f3_100_err", {31'b0, r_err}, 32'd1);
    chk("st_f3_100_we", {31'b0, r_wr}, 32'd0);
    @(posedge clk); #1;
    chk("err_mem4", mem[4], 32'h8001AAEF);

    // Back-to-back byte loads, one response per cycle
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b000; addr = 32'h10 + 32'(i);
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_vld", {31'b0, rsp_valid}, 32'd1);
        chk("b2b_rd", rdata, b2b_exp[i-1]);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_vld", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rd", rdata, b2b_exp[3]);

    // Store followed by a held load: load waits out the WRITE cycle
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req_we = 1'b0;
    @(negedge clk);
    chk("hold_ready_wr", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_vld", {31'b0, rsp_valid}, 32'd1);
    chk("hold_rd", rdata, 32'h12345678);

    // Address wraps modulo 4 KiB
    do_req(1'b0, 3'b010, 32'h00001010, 32'h0, r_err, r_rd, r_wr);
    chk("wrap_rd", r_rd, 32'h8001AAEF);

    // Reset during WRITE aborts the write and its response
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("abort_we", {31'b0, mem_WE}, 32'd0);
    chk("abort_vld", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem12", mem[12], 32'hA5A5000C);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, r_err, r_rd, r_wr);
    chk("abort_lw", r_rd, 32'hA5A5000C);

    // Final memory image against the model
    @(posedge clk); #1;
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", 32'(diffs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
